// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
//   RS_TYPE_WIDTH  width of the ALU op-type field
//   ROB_ID_WIDTH   width of a ROB id / operand tag
//   XLEN           operand/result width
//   cdb_t          one result broadcast (ALU or LSB bus)
//   opnd_t         one source operand: pending flag, producer tag, value
//   rs_entry_t     one stored op
//   issue_t        fields handed to the ALU on issue
//   snoop()        captures a broadcast result into a pending operand
package alu_reservation_station_pkg;

  localparam int RS_TYPE_WIDTH = 4;
  localparam int ROB_ID_WIDTH  = 32;
  localparam int XLEN          = 32;

  typedef enum logic [RS_TYPE_WIDTH-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC
  } alu_op_e;

  typedef struct packed {
    logic                    rdy;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [XLEN-1:0]         result;
  } cdb_t;

  typedef struct packed {
    logic                    busy;
    logic [ROB_ID_WIDTH-1:0] tag;
    logic [XLEN-1:0]         val;
  } opnd_t;

  typedef struct packed {
    logic [RS_TYPE_WIDTH-1:0] op;
    logic [ROB_ID_WIDTH-1:0]  rob_id;
    opnd_t                    j;
    opnd_t                    k;
    logic [XLEN-1:0]          imm;
  } rs_entry_t;

  typedef struct packed {
    logic [RS_TYPE_WIDTH-1:0] op;
    logic [ROB_ID_WIDTH-1:0]  rob_id;
    logic [XLEN-1:0]          data_j;
    logic [XLEN-1:0]          data_k;
    logic [XLEN-1:0]          imm;
  } issue_t;

  // A pending operand picks up the value from whichever bus carries its tag.
  // The ALU bus is checked first so it wins if both ever carry the same tag.
  function automatic opnd_t snoop(opnd_t o, cdb_t alu, cdb_t lsb);
    opnd_t r;
    r = o;
    if (o.busy) begin
      if (alu.rdy && (alu.rob_id == o.tag)) begin
        r.busy = 1'b0;
        r.val  = alu.result;
      end else if (lsb.rdy && (lsb.rob_id == o.tag)) begin
        r.busy = 1'b0;
        r.val  = lsb.result;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Bundle of the reservation station's data-path signals.
//   dispatch_*    new op from decode/dispatch
//   full          station has no free entry
//   alu_bus_*     ALU result broadcast
//   lsb_bus_*     load result broadcast
//   alu_*         registered issue to the ALU
// Modports: master = upstream/bus side, slave = the reservation station.
interface alu_reservation_station_if;
  import alu_reservation_station_pkg::*;

  logic                     dispatch_en;
  logic [RS_TYPE_WIDTH-1:0] dispatch_type;
  logic [ROB_ID_WIDTH-1:0]  dispatch_rob_id;
  logic                     dispatch_qj_busy;
  logic [ROB_ID_WIDTH-1:0]  dispatch_qj;
  logic [XLEN-1:0]          dispatch_vj;
  logic                     dispatch_qk_busy;
  logic [ROB_ID_WIDTH-1:0]  dispatch_qk;
  logic [XLEN-1:0]          dispatch_vk;
  logic [XLEN-1:0]          dispatch_imm;
  logic                     full;

  logic                     alu_bus_rdy;
  logic [ROB_ID_WIDTH-1:0]  alu_bus_rob_id;
  logic [XLEN-1:0]          alu_bus_result;
  logic                     lsb_bus_rdy;
  logic [ROB_ID_WIDTH-1:0]  lsb_bus_rob_id;
  logic [XLEN-1:0]          lsb_bus_result;

  logic                     alu_en;
  logic [RS_TYPE_WIDTH-1:0] alu_type;
  logic [ROB_ID_WIDTH-1:0]  alu_rob_id;
  logic [XLEN-1:0]          alu_data_j;
  logic [XLEN-1:0]          alu_data_k;
  logic [XLEN-1:0]          alu_imm;

  modport master (
    output dispatch_en, dispatch_type, dispatch_rob_id,
           dispatch_qj_busy, dispatch_qj, dispatch_vj,
           dispatch_qk_busy, dispatch_qk, dispatch_vk, dispatch_imm,
           alu_bus_rdy, alu_bus_rob_id, alu_bus_result,
           lsb_bus_rdy, lsb_bus_rob_id, lsb_bus_result,
    input  full, alu_en, alu_type, alu_rob_id, alu_data_j, alu_data_k, alu_imm
  );

  modport slave (
    input  dispatch_en, dispatch_type, dispatch_rob_id,
           dispatch_qj_busy, dispatch_qj, dispatch_vj,
           dispatch_qk_busy, dispatch_qk, dispatch_vk, dispatch_imm,
           alu_bus_rdy, alu_bus_rob_id, alu_bus_result,
           lsb_bus_rdy, lsb_bus_rob_id, lsb_bus_result,
    output full, alu_en, alu_type, alu_rob_id, alu_data_j, alu_data_k, alu_imm
  );

endinterface

// File: rtl/alu_reservation_station_pick_first.sv
// rs_pick_first: lowest-set-bit encoder.
//   req    request vector
//   found  any bit of req set
//   idx    index of the lowest set bit (0 when none)
module rs_pick_first #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are
// known, snooping the ALU and LSB result buses, and issues at most one ready
// op per cycle into registers that feed the single-cycle ALU directly.
//   clk_in   clock, all state changes on posedge
//   rst_in   synchronous active-high reset
//   rdy_in   global enable; low freezes every register
//   flush    mispredict flush; drops all entries and any same-cycle dispatch
//   rs       dispatch / broadcast / issue bundle (slave side)
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic flush,
  alu_reservation_station_if.slave rs
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] valid;
  logic [RS_SIZE-1:0] ready;
  rs_entry_t          ent [RS_SIZE];

  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;
  opnd_t              disp_j_raw;
  opnd_t              disp_k_raw;
  rs_entry_t          disp;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;

  logic               alu_en_q;
  issue_t             iss_q;

  assign alu_cdb = '{rdy: rs.alu_bus_rdy, rob_id: rs.alu_bus_rob_id,
                     result: rs.alu_bus_result};
  assign lsb_cdb = '{rdy: rs.lsb_bus_rdy, rob_id: rs.lsb_bus_rob_id,
                     result: rs.lsb_bus_result};

  assign disp_j_raw = '{busy: rs.dispatch_qj_busy, tag: rs.dispatch_qj,
                        val: rs.dispatch_vj};
  assign disp_k_raw = '{busy: rs.dispatch_qk_busy, tag: rs.dispatch_qk,
                        val: rs.dispatch_vk};

  // Incoming op with same-cycle bypass: an operand whose producer is on a bus
  // right now is stored already resolved, otherwise it would miss the
  // broadcast forever.
  always_comb begin
    disp        = '0;
    disp.op     = rs.dispatch_type;
    disp.rob_id = rs.dispatch_rob_id;
    disp.imm    = rs.dispatch_imm;
    disp.j      = snoop(disp_j_raw, alu_cdb, lsb_cdb);
    disp.k      = snoop(disp_k_raw, alu_cdb, lsb_cdb);
  end

  // Readiness comes from registered state only, so an operand woken this
  // cycle is first eligible next cycle.
  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ready
    assign ready[i] = valid[i] & ~ent[i].j.busy & ~ent[i].k.busy;
  end

  rs_pick_first #(.N(RS_SIZE)) u_free (
    .req   (~valid),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick_first #(.N(RS_SIZE)) u_sel (
    .req   (ready),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // full looks at pre-edge state: a slot freed by this cycle's issue is not
  // offered to dispatch until the next cycle.
  assign rs.full = &valid;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid    <= '0;
      alu_en_q <= 1'b0;
      iss_q    <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        valid    <= '0;
        alu_en_q <= 1'b0;
      end else begin
        // Wakeup of every resident entry.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid[i]) begin
            ent[i].j <= snoop(ent[i].j, alu_cdb, lsb_cdb);
            ent[i].k <= snoop(ent[i].k, alu_cdb, lsb_cdb);
          end
        end

        // Issue; the selected entry is ready, so wakeup left it unchanged.
        if (sel_found) begin
          alu_en_q       <= 1'b1;
          iss_q.op       <= ent[sel_idx].op;
          iss_q.rob_id   <= ent[sel_idx].rob_id;
          iss_q.data_j   <= ent[sel_idx].j.val;
          iss_q.data_k   <= ent[sel_idx].k.val;
          iss_q.imm      <= ent[sel_idx].imm;
          valid[sel_idx] <= 1'b0;
        end else begin
          alu_en_q <= 1'b0;
        end

        // Dispatch lands in an invalid slot, never the issuing or waking
        // ones. free_found is low exactly when full, so dispatch into a full
        // station is dropped.
        if (rs.dispatch_en && free_found) begin
          valid[free_idx] <= 1'b1;
          ent[free_idx]   <= disp;
        end
      end
    end
  end

  assign rs.alu_en     = alu_en_q;
  assign rs.alu_type   = iss_q.op;
  assign rs.alu_rob_id = iss_q.rob_id;
  assign rs.alu_data_j = iss_q.data_j;
  assign rs.alu_data_k = iss_q.data_k;
  assign rs.alu_imm    = iss_q.imm;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: a cycle table of directed vectors,
// hand-written multi-cycle sequences, then randomized traffic checked against
// a behavioural model of the station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int N = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station_if ifc ();

  alu_reservation_station #(.RS_SIZE(N)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .rs     (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  typ;
    logic [31:0] rob, imm;
    logic        jb;
    logic [31:0] qj, vj;
    logic        kb;
    logic [31:0] qk, vk;
  } mop_t;

  mop_t        m_e [N];
  bit          m_v [N];
  logic        m_en = 1'b0;
  logic [3:0]  m_typ = '0;
  logic [31:0] m_rob = '0, m_j = '0, m_k = '0, m_imm = '0;

  function automatic void cap(inout logic b, input logic [31:0] q, inout logic [31:0] v);
    if (!b) return;
    if (ifc.alu_bus_rdy && ifc.alu_bus_rob_id == q) begin
      v = ifc.alu_bus_result; b = 1'b0;
    end else if (ifc.lsb_bus_rdy && ifc.lsb_bus_rob_id == q) begin
      v = ifc.lsb_bus_result; b = 1'b0;
    end
  endfunction

  function automatic logic m_full();
    foreach (m_v[i]) if (!m_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   pick, free;
    logic was_full;
    mop_t d;
    if (rst_in) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_en = 1'b0; m_typ = '0; m_rob = '0; m_j = '0; m_k = '0; m_imm = '0;
      return;
    end
    if (!rdy_in) return;
    if (flush) begin
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_en = 1'b0;
      return;
    end
    pick = -1; free = -1;
    was_full = m_full();
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && !m_e[i].jb && !m_e[i].kb && pick < 0) pick = i;
      if (!m_v[i] && free < 0) free = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        d = m_e[i];
        cap(d.jb, d.qj, d.vj);
        cap(d.kb, d.qk, d.vk);
        m_e[i] = d;
      end
    end
    if (pick >= 0) begin
      m_en = 1'b1; m_typ = m_e[pick].typ; m_rob = m_e[pick].rob;
      m_j = m_e[pick].vj; m_k = m_e[pick].vk; m_imm = m_e[pick].imm;
      m_v[pick] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (ifc.dispatch_en && !was_full) begin
      d.typ = ifc.dispatch_type; d.rob = ifc.dispatch_rob_id; d.imm = ifc.dispatch_imm;
      d.jb = ifc.dispatch_qj_busy; d.qj = ifc.dispatch_qj; d.vj = ifc.dispatch_vj;
      d.kb = ifc.dispatch_qk_busy; d.qk = ifc.dispatch_qk; d.vk = ifc.dispatch_vk;
      cap(d.jb, d.qj, d.vj);
      cap(d.kb, d.qk, d.vk);
      m_e[free] = d;
      m_v[free] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    ifc.dispatch_en = 1'b0; ifc.dispatch_type = '0; ifc.dispatch_rob_id = '0;
    ifc.dispatch_qj_busy = 1'b0; ifc.dispatch_qj = '0; ifc.dispatch_vj = '0;
    ifc.dispatch_qk_busy = 1'b0; ifc.dispatch_qk = '0; ifc.dispatch_vk = '0;
    ifc.dispatch_imm = '0;
    ifc.alu_bus_rdy = 1'b0; ifc.alu_bus_rob_id = '0; ifc.alu_bus_result = '0;
    ifc.lsb_bus_rdy = 1'b0; ifc.lsb_bus_rob_id = '0; ifc.lsb_bus_result = '0;
  endtask

  task automatic set_disp(input logic [31:0] rob, input logic jb, input logic [31:0] qj,
                          input logic [31:0] vj, input logic kb, input logic [31:0] qk,
                          input logic [31:0] vk);
    ifc.dispatch_en = 1'b1; ifc.dispatch_type = ALU_ADD; ifc.dispatch_rob_id = rob;
    ifc.dispatch_qj_busy = jb; ifc.dispatch_qj = qj; ifc.dispatch_vj = vj;
    ifc.dispatch_qk_busy = kb; ifc.dispatch_qk = qk; ifc.dispatch_vk = vk;
    ifc.dispatch_imm = rob + 32'd1000;
  endtask

  task automatic set_alu(input logic [31:0] id, input logic [31:0] res);
    ifc.alu_bus_rdy = 1'b1; ifc.alu_bus_rob_id = id; ifc.alu_bus_result = res;
  endtask

  task automatic set_lsb(input logic [31:0] id, input logic [31:0] res);
    ifc.lsb_bus_rdy = 1'b1; ifc.lsb_bus_rob_id = id; ifc.lsb_bus_result = res;
  endtask

  task automatic chk_iss(input string nm, input logic en, input logic [31:0] rob,
                         input logic [31:0] j, input logic [31:0] k);
    chk({nm, " en"}, 32'(ifc.alu_en), 32'(en));
    if (en) begin
      chk({nm, " rob"}, ifc.alu_rob_id, rob);
      chk({nm, " j"}, ifc.alu_data_j, j);
      chk({nm, " k"}, ifc.alu_data_k, k);
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic [31:0] rst, den, rob, jb, qj, vj, kb, qk, vk;
    logic [31:0] ab, aid, ares, lb, lid, lres;
    logic [31:0] en, erob, ej, ek, efull;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(
    input logic [31:0] rst, den, rob, jb, qj, vj, kb, qk, vk,
    input logic [31:0] ab, aid, ares, lb, lid, lres,
    input logic [31:0] en, erob, ej, ek, efull);
    vec_t v;
    v.rst = rst; v.den = den; v.rob = rob; v.jb = jb; v.qj = qj; v.vj = vj;
    v.kb = kb; v.qk = qk; v.vk = vk; v.ab = ab; v.aid = aid; v.ares = ares;
    v.lb = lb; v.lid = lid; v.lres = lres;
    v.en = en; v.erob = erob; v.ej = ej; v.ek = ek; v.efull = efull;
    return v;
  endfunction

  initial begin
    idle();

    //                 rst den rob jb qj vj kb qk vk   ab aid ares  lb lid lres  en rob j  k  full
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 3, 0, 0, 5, 0, 0, 7,     0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 1, 4, 1, 2, 0, 0, 0, 1,     0, 0, 0,     0, 0, 0,     0, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 2, 16,    0, 3, 5, 7, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1, 4, 16, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 4, 16, 1, 0));
    tbl.push_back(mkv(0, 1, 5, 0, 0, 8, 1, 9, 0,     1, 9, 42,    0, 0, 0,     0, 4, 16, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1, 5, 8, 42, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 5, 8, 42, 0));
    tbl.push_back(mkv(0, 1, 6, 1, 20, 0, 0, 0, 3,    1, 21, 77,   0, 0, 0,     0, 5, 8, 42, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 5, 8, 42, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 20, 55,   1, 20, 99,   0, 5, 8, 42, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1, 6, 55, 3, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 6, 55, 3, 0));

    foreach (tbl[r]) begin
      rst_in = tbl[r].rst[0];
      idle();
      if (tbl[r].den[0])
        set_disp(tbl[r].rob, tbl[r].jb[0], tbl[r].qj, tbl[r].vj, tbl[r].kb[0], tbl[r].qk, tbl[r].vk);
      if (tbl[r].ab[0]) set_alu(tbl[r].aid, tbl[r].ares);
      if (tbl[r].lb[0]) set_lsb(tbl[r].lid, tbl[r].lres);
      tick();
      chk($sformatf("row%0d en", r), 32'(ifc.alu_en), tbl[r].en);
      chk($sformatf("row%0d rob", r), ifc.alu_rob_id, tbl[r].erob);
      chk($sformatf("row%0d j", r), ifc.alu_data_j, tbl[r].ej);
      chk($sformatf("row%0d k", r), ifc.alu_data_k, tbl[r].ek);
      chk($sformatf("row%0d full", r), 32'(ifc.full), tbl[r].efull);
    end
    rst_in = 1'b0;
    idle();

    // ---- fill to full, overflow dispatch, slot reuse after issue ----
    for (int i = 0; i < N; i++) begin
      set_disp(100 + i, 1'b1, 200 + i, 0, 1'b0, 0, i);
      tick(); idle();
      chk($sformatf("fill%0d full", i), 32'(ifc.full), (i == N - 1) ? 32'd1 : 32'd0);
    end
    set_disp(999, 1'b1, 300, 0, 1'b0, 0, 0);   // station full: dropped
    tick(); idle();
    chk("ovf full", 32'(ifc.full), 32'd1);
    set_alu(200, 32'h55);
    tick(); idle();
    chk_iss("wake0", 1'b0, 0, 0, 0);
    chk("wake0 full", 32'(ifc.full), 32'd1);
    set_disp(777, 1'b0, 0, 1, 1'b0, 0, 2);     // still full before this edge
    tick(); idle();
    chk_iss("iss0", 1'b1, 100, 32'h55, 0);
    chk("iss0 full", 32'(ifc.full), 32'd0);
    tick();
    chk_iss("no777", 1'b0, 0, 0, 0);
    for (int k = 1; k < N; k++) begin
      set_alu(200 + k, 3 * k);
      tick(); idle(); tick();
      chk_iss($sformatf("drain%0d", k), 1'b1, 100 + k, 3 * k, k);
    end
    set_alu(300, 1);
    tick(); idle(); tick();
    chk_iss("no999", 1'b0, 0, 0, 0);
    chk("empty full", 32'(ifc.full), 32'd0);

    // ---- lowest-index select: ready in slots 5, 1, 3 ----
    for (int i = 0; i < 6; i++) begin
      set_disp(500 + i, 1'b1, 400 + i, 0, 1'b0, 0, i);
      tick(); idle();
    end
    set_alu(405, 5); set_lsb(401, 1);
    tick(); idle();
    chk_iss("sel w", 1'b0, 0, 0, 0);
    set_lsb(403, 3);
    tick(); idle();
    chk_iss("sel a", 1'b1, 501, 1, 1);
    tick();
    chk_iss("sel b", 1'b1, 503, 3, 3);
    tick();
    chk_iss("sel c", 1'b1, 505, 5, 5);
    tick();
    chk_iss("sel d", 1'b0, 0, 0, 0);

    // ---- flush with 4 valid entries and an issue in flight ----
    set_disp(506, 1'b0, 0, 11, 1'b0, 0, 12);
    tick(); idle();
    set_disp(507, 1'b1, 407, 0, 1'b0, 0, 13);
    tick(); idle();
    chk_iss("pre flush", 1'b1, 506, 11, 12);
    flush = 1'b1;
    set_disp(508, 1'b0, 0, 1, 1'b0, 0, 1);
    tick(); idle();
    flush = 1'b0;
    chk_iss("flush", 1'b0, 0, 0, 0);
    chk("flush full", 32'(ifc.full), 32'd0);
    set_alu(400, 1); set_lsb(402, 2);
    tick(); idle();
    chk_iss("postfl a", 1'b0, 0, 0, 0);
    set_alu(404, 1); set_lsb(407, 2);
    tick(); idle();
    chk_iss("postfl b", 1'b0, 0, 0, 0);
    tick();
    chk_iss("postfl c", 1'b0, 0, 0, 0);
    tick();
    chk_iss("postfl d", 1'b0, 0, 0, 0);

    // ---- rdy_in low freezes everything ----
    set_disp(600, 1'b0, 0, 1, 1'b0, 0, 2);
    tick();
    set_disp(601, 1'b0, 0, 3, 1'b0, 0, 4);
    tick(); idle();
    chk_iss("hold pre", 1'b1, 600, 1, 2);
    rdy_in = 1'b0;
    set_disp(602, 1'b0, 0, 5, 1'b0, 0, 6);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_iss($sformatf("hold%0d", c), 1'b1, 600, 1, 2);
    end
    rdy_in = 1'b1;
    idle();
    tick();
    chk_iss("resume", 1'b1, 601, 3, 4);
    tick();
    chk_iss("resume idle", 1'b0, 0, 0, 0);

    // ---- randomized traffic against the model ----
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(9) != 0);
      flush  = ($urandom_range(63) == 0);
      ifc.dispatch_en      = ($urandom_range(9) < 6);
      ifc.dispatch_type    = RS_TYPE_WIDTH'($urandom_range(11));
      ifc.dispatch_rob_id  = $urandom;
      ifc.dispatch_qj_busy = ($urandom_range(1) == 1);
      ifc.dispatch_qj      = $urandom_range(15);
      ifc.dispatch_vj      = $urandom;
      ifc.dispatch_qk_busy = ($urandom_range(1) == 1);
      ifc.dispatch_qk      = $urandom_range(15);
      ifc.dispatch_vk      = $urandom;
      ifc.dispatch_imm     = $urandom;
      ifc.alu_bus_rdy      = ($urandom_range(1) == 1);
      ifc.alu_bus_rob_id   = $urandom_range(15);
      ifc.alu_bus_result   = $urandom;
      ifc.lsb_bus_rdy      = ($urandom_range(1) == 1);
      ifc.lsb_bus_rob_id   = $urandom_range(15);
      ifc.lsb_bus_result   = $urandom;
      tick();
      chk($sformatf("rnd%0d en", c), 32'(ifc.alu_en), 32'(m_en));
      chk($sformatf("rnd%0d full", c), 32'(ifc.full), 32'(m_full()));
      chk($sformatf("rnd%0d type", c), 32'(ifc.alu_type), 32'(m_typ));
      chk($sformatf("rnd%0d rob", c), ifc.alu_rob_id, m_rob);
      chk($sformatf("rnd%0d j", c), ifc.alu_data_j, m_j);
      chk($sformatf("rnd%0d k", c), ifc.alu_data_k, m_k);
      chk($sformatf("rnd%0d imm", c), ifc.alu_imm, m_imm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
